// File: rtl/l0_skew_feeder_if.sv
// Bus bundle for the L0 skew feeder: push/pop controls, lane data out, occupancy flags.
interface l0_skew_feeder_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic                wr;
  logic [row*bw-1:0]   in;
  logic                rd;
  logic [row*bw-1:0]   out;
  logic [row-1:0]      o_valid;
  logic                o_full;
  logic                o_ready;
  logic                o_empty;

  modport master (
    output wr, in, rd,
    input  out, o_valid, o_full, o_ready, o_empty
  );

  modport slave (
    input  wr, in, rd,
    output out, o_valid, o_full, o_ready, o_empty
  );
endinterface

// File: rtl/l0_skew_feeder.sv
// Lane-parallel activation FIFOs whose pops are diagonally skewed so lane k
// reaches row k of the MAC array k cycles after lane 0.
module l0_skew_feeder #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  l0_skew_feeder_if.slave   bus
);

  localparam int AW = $clog2(depth);
  typedef logic [AW:0] ptr_t;

  logic [bw-1:0]     mem_q [row][depth];
  ptr_t              wptr_q, wptr_d;
  ptr_t              rptr_q [row];
  ptr_t              rptr_d [row];
  logic [row-2:0]    sk_q, sk_d;
  logic [row*bw-1:0] out_q, out_d;
  logic [row-1:0]    vld_q, vld_d;

  logic              full, empty, push, pop0;
  logic [row-1:0]    pop;
  ptr_t              occ_last;

  // Lane row-1 trails every other lane, so it alone decides fullness.
  always_comb begin
    occ_last = wptr_q - rptr_q[row-1];
    full     = (occ_last == ptr_t'(depth));
    empty    = (wptr_q == rptr_q[0]);
    push     = bus.wr & ~full;
    pop0     = bus.rd & ~empty;
    pop      = {sk_q, pop0};
  end

  always_comb begin
    wptr_d = push ? wptr_q + ptr_t'(1) : wptr_q;
    sk_d    = '0;
    sk_d[0] = pop0;
    for (int k = 1; k < row - 1; k++) begin
      sk_d[k] = sk_q[k-1];
    end
    out_d = out_q;
    vld_d = pop;
    for (int k = 0; k < row; k++) begin
      rptr_d[k] = rptr_q[k];
      if (pop[k]) begin
        out_d[k*bw +: bw] = mem_q[k][rptr_q[k][AW-1:0]];
        rptr_d[k]         = rptr_q[k] + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      sk_q   <= '0;
      out_q  <= '0;
      vld_q  <= '0;
      for (int k = 0; k < row; k++) begin
        rptr_q[k] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      sk_q   <= sk_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      for (int k = 0; k < row; k++) begin
        rptr_q[k] <= rptr_d[k];
      end
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < row; k++) begin
        mem_q[k][wptr_q[AW-1:0]] <= bus.in[k*bw +: bw];
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = vld_q;
  assign bus.o_full  = full;
  assign bus.o_ready = ~full;
  assign bus.o_empty = empty;

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Scoreboard bench: a vector-queue model predicts per-lane (cycle, value) pairs
// that a negedge monitor matches against the skewed outputs.
module tb_l0_skew_feeder;
  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam int VW    = ROW * BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l0_skew_feeder_if #(.row(ROW), .bw(BW)) bus ();
  l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int            cyc;
    logic [BW-1:0] val;
  } exp_t;

  exp_t          lq [ROW][$];
  logic [VW-1:0] mq [$];
  int            iss [$];
  logic [BW-1:0] lastv [ROW];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  int            n_push = 0;
  int            lastpops = 0;
  exp_t          me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Monitor: every lane valid must match the front of that lane's expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < ROW; k++) begin
        while (lq[k].size() > 0 && lq[k][0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL lane%0d missing valid: actual=none required=%0h at cycle %0d",
                   k, lq[k][0].val, lq[k][0].cyc);
          void'(lq[k].pop_front());
        end
        if (bus.o_valid[k]) begin
          if (lq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d unexpected valid at cycle %0d: actual=%0h required=no valid",
                     k, cyc, bus.out[k*BW +: BW]);
          end else begin
            me = lq[k].pop_front();
            chk($sformatf("lane%0d timing", k), cyc, me.cyc);
            chk($sformatf("lane%0d data", k), 32'(bus.out[k*BW +: BW]), 32'(me.val));
            lastv[k] = me.val;
          end
        end else begin
          chk($sformatf("lane%0d hold", k), 32'(bus.out[k*BW +: BW]), 32'(lastv[k]));
        end
      end
    end
  end

  // One clock of stimulus; the model decides acceptance from occupancy before the edge.
  task automatic step(input logic w, input logic [VW-1:0] v, input logic r);
    int            t;
    bit            fm, em;
    logic [VW-1:0] vec;
    t = cyc + 1;
    while (iss.size() > 0 && iss[0] + ROW - 1 <= t - 1) begin
      void'(iss.pop_front());
      lastpops++;
    end
    fm = ((n_push - lastpops) == DEPTH);
    em = (mq.size() == 0);
    chk("o_full", 32'(bus.o_full), 32'(fm));
    chk("o_empty", 32'(bus.o_empty), 32'(em));
    chk("o_ready", 32'(bus.o_ready), 32'(!fm));
    if (r && !em) begin
      vec = mq.pop_front();
      for (int k = 0; k < ROW; k++) begin
        lq[k].push_back('{cyc: t + k, val: vec[k*BW +: BW]});
      end
      iss.push_back(t);
    end
    if (w && !fm) begin
      mq.push_back(v);
      n_push++;
    end
    bus.wr = w;
    bus.in = v;
    bus.rd = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic clear_model();
    mq.delete();
    iss.delete();
    for (int k = 0; k < ROW; k++) begin
      lq[k].delete();
      lastv[k] = '0;
    end
    n_push   = 0;
    lastpops = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " out"}, bus.out, '0);
    chk({tag, " o_valid"}, 32'(bus.o_valid), 0);
    chk({tag, " o_empty"}, 32'(bus.o_empty), 1);
    chk({tag, " o_full"}, 32'(bus.o_full), 0);
    chk({tag, " o_ready"}, 32'(bus.o_ready), 1);
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    clear_model();
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] rv;
    reset  = 1'b0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.in = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("reset");

    // Single wavefront: lane k must deliver k+1.
    step(1'b1, 32'h8765_4321, 1'b0);
    step(1'b1, 32'h0FED_CBA9, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(10);

    // Streaming reads.
    for (int i = 0; i < 4; i++) begin
      rv = $urandom();
      step(1'b1, rv, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    idle(10);

    // Drain what is left, then reads on an empty FIFO.
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    idle(10);

    // Fill to full, one ignored push, drain completely.
    for (int i = 0; i < DEPTH + 1; i++) begin
      rv = $urandom();
      step(1'b1, rv, 1'b0);
    end
    for (int i = 0; i < DEPTH + 3; i++) step(1'b0, '0, 1'b1);
    idle(10);

    // Pointer wrap with simultaneous push and pop at steady occupancy.
    for (int i = 0; i < 2; i++) begin
      rv = $urandom();
      step(1'b1, rv, 1'b0);
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rv = $urandom();
      step(1'b1, rv, 1'b1);
    end
    idle(10);

    // Random traffic with an asynchronous reset landing mid-wavefront.
    for (int i = 0; i < 2000; i++) begin
      rv = $urandom();
      step(1'($urandom_range(0, 99) < 55), rv, 1'($urandom_range(0, 99) < 50));
      if (i == 1000) mid_reset();
    end
    idle(12);
    for (int k = 0; k < ROW; k++) begin
      chk($sformatf("lane%0d drained", k), 32'(lq[k].size()), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
